// File: rtl/pe_grant_drain.sv
`default_nettype none
// ============================================================================
//  Module   : pe_grant_drain
//  Purpose  : Sticky request collector and grant sequencer. Single-cycle
//             request pulses accumulate in a pending bitmap. The highest-index
//             pending bit is issued through a valid/ready output register and
//             retired as it is issued, giving one grant per cycle under
//             back-pressure.
//  Ports    : clk         - rising-edge clock
//             rst         - asynchronous active-high reset
//             req_set     - N one-cycle set pulses, bit i requests index i
//             flush       - synchronous clear of pending bitmap and output reg
//             out_valid   - out_index holds a grant
//             out_ready   - consumer accepts the grant this cycle
//             out_index   - granted index (IW bits)
//             pending_any - registered OR of the pending bitmap
//             dup_cnt     - saturating count of cycles with a duplicate request
//  Revision : 1.0 - initial release
// ============================================================================
module pe_grant_drain #(
  parameter int N  = 256,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_set,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_index,
  output logic          pending_any,
  output logic [15:0]   dup_cnt
);

  localparam int NG = N / 64;

  logic [N-1:0]  pending;
  logic [N-1:0]  pending_next;
  logic [N-1:0]  clr_mask;
  logic [IW-1:0] enc;
  logic          pending_any_comb;
  logic          load;
  logic          dup_hit;

  logic [NG-1:0] grp_valid;
  logic [5:0]    grp_idx [NG];

  // --------------------------------------------------------------------------
  // Per-group 64-bit encoders. The loop runs low-to-high so the last (highest)
  // set bit wins, matching the downstream encoder's highest-wins rule.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic [63:0] slice;
    logic [5:0]  idx;

    assign slice = pending[g*64 +: 64];

    always_comb begin
      idx = '0;
      for (int i = 0; i < 64; i++) begin
        if (slice[i]) idx = 6'(i);
      end
    end

    assign grp_valid[g] = |slice;
    assign grp_idx[g]   = idx;
  end

  // --------------------------------------------------------------------------
  // Group-level priority: highest non-empty group supplies the upper index bits.
  // --------------------------------------------------------------------------
  if (NG == 1) begin : g_sel_single
    assign enc = grp_idx[0];
  end else begin : g_sel_multi
    localparam int GW = IW - 6;
    logic [GW-1:0] gsel;
    logic [5:0]    lsel;

    always_comb begin
      gsel = '0;
      lsel = '0;
      for (int g = 0; g < NG; g++) begin
        if (grp_valid[g]) begin
          gsel = GW'(g);
          lsel = grp_idx[g];
        end
      end
    end

    assign enc = {gsel, lsel};
  end

  assign pending_any_comb = |grp_valid;
  assign load             = pending_any_comb && (!out_valid || out_ready);

  // The new request is OR'd in after the clear, so a same-cycle set and clear
  // of one bit leaves it pending (re-queued).
  assign clr_mask     = load ? ({{(N-1){1'b0}}, 1'b1} << enc) : '0;
  assign pending_next = (pending & ~clr_mask) | req_set;

  // Requests in a flush cycle are dropped, so they cannot count as duplicates.
  assign dup_hit = !flush && (|(req_set & pending & ~clr_mask));

  // --------------------------------------------------------------------------
  // Pending bitmap and output register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= '0;
      pending_any <= 1'b0;
      out_valid   <= 1'b0;
      out_index   <= '0;
    end else if (flush) begin
      // Flush beats a concurrent load; out_index keeps its last value.
      pending     <= '0;
      pending_any <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      pending     <= pending_next;
      pending_any <= |pending_next;
      if (load) begin
        out_valid <= 1'b1;
        out_index <= enc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Duplicate counter: one increment per cycle with any duplicate, saturating.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dup_cnt <= '0;
    end else if (dup_hit && (dup_cnt != 16'hFFFF)) begin
      dup_cnt <= dup_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_grant_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_grant_drain
//  Purpose  : Self-checking bench for pe_grant_drain (N=256). Expected grant
//             indices are queued as requests are driven and popped on every
//             accepted handshake; direct checks cover timing and counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_grant_drain;

  localparam int N  = 256;
  localparam int IW = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_set;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic          pending_any;
  logic [15:0]   dup_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int expq[$];

  pe_grant_drain #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_set     (req_set),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .pending_any (pending_any),
    .dup_cnt     (dup_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] bit_of(input int i);
    logic [N-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  // Push every set bit of a mask in descending order (expected grant order).
  task automatic push_desc(input logic [N-1:0] m);
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) expq.push_back(i);
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int c;
    c = 0;
    while (expq.size() != 0 && c < max_cycles) begin
      tick();
      c++;
    end
    if (expq.size() != 0) check_val("drain_timeout", 32'(expq.size()), 32'd0);
  endtask

  // Scoreboard: every accepted grant must match the head of the queue.
  always @(negedge clk) begin
    int e;
    if (out_valid && out_ready) begin
      e = (expq.size() != 0) ? expq.pop_front() : 32'hDEAD;
      check_val("grant", 32'(out_index), 32'(e));
    end
  end

  initial begin
    logic [N-1:0] m;

    rst       = 1'b1;
    req_set   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check_val("rst_valid",  32'(out_valid),   32'd0);
    check_val("rst_index",  32'(out_index),   32'd0);
    check_val("rst_pany",   32'(pending_any), 32'd0);
    check_val("rst_dup",    32'(dup_cnt),     32'd0);

    // ---------------- Ordering ----------------
    out_ready = 1'b1;
    m = bit_of(3) | bit_of(64) | bit_of(200);
    req_set = m;
    push_desc(m);
    tick();
    req_set = '0;
    check_val("ord_c2_valid", 32'(out_valid),   32'd0);
    check_val("ord_c2_pany",  32'(pending_any), 32'd1);
    tick();
    check_val("ord_c3_valid", 32'(out_valid), 32'd1);
    check_val("ord_c3_idx",   32'(out_index), 32'd200);
    tick();
    check_val("ord_c4_idx",   32'(out_index), 32'd64);
    tick();
    check_val("ord_c5_idx",   32'(out_index), 32'd3);
    check_val("ord_c5_pany",  32'(pending_any), 32'd0);
    tick();
    check_val("ord_c6_valid", 32'(out_valid), 32'd0);
    wait_drain(10);

    // ---------------- Backpressure ----------------
    out_ready = 1'b0;
    req_set = bit_of(255);
    push_desc(bit_of(255));
    tick();
    req_set = '0;
    tick();
    for (int k = 0; k < 10; k++) begin
      check_val("bp_hold_valid", 32'(out_valid), 32'd1);
      check_val("bp_hold_idx",   32'(out_index), 32'd255);
      if (k == 3) begin
        req_set = bit_of(10);
        push_desc(bit_of(10));
      end else begin
        req_set = '0;
      end
      tick();
    end
    req_set   = '0;
    out_ready = 1'b1;
    tick();
    check_val("bp_next_idx",   32'(out_index), 32'd10);
    check_val("bp_next_valid", 32'(out_valid), 32'd1);
    tick();
    check_val("bp_end_valid",  32'(out_valid), 32'd0);
    wait_drain(10);

    // ---------------- Duplicate ----------------
    out_ready = 1'b0;
    m = bit_of(100) | bit_of(50);
    req_set = m;
    push_desc(m);
    tick();
    req_set = bit_of(50);
    tick();
    req_set = '0;
    check_val("dup_idx",   32'(out_index), 32'd100);
    check_val("dup_cnt1",  32'(dup_cnt),   32'd1);
    out_ready = 1'b1;
    tick();
    check_val("dup_next",  32'(out_index), 32'd50);
    tick();
    check_val("dup_end_valid", 32'(out_valid), 32'd0);
    repeat (3) tick();
    check_val("dup_once_q", 32'(expq.size()), 32'd0);

    // ---------------- Set/clear collision ----------------
    req_set = bit_of(63);
    push_desc(bit_of(63));
    tick();
    req_set = bit_of(63);
    push_desc(bit_of(63));
    tick();
    req_set = '0;
    check_val("col_first_idx",  32'(out_index),   32'd63);
    check_val("col_first_pany", 32'(pending_any), 32'd1);
    tick();
    check_val("col_second_vld", 32'(out_valid),   32'd1);
    check_val("col_second_idx", 32'(out_index),   32'd63);
    check_val("col_pany_clr",   32'(pending_any), 32'd0);
    tick();
    check_val("col_end_valid",  32'(out_valid),   32'd0);
    check_val("col_dup",        32'(dup_cnt),     32'd1);
    wait_drain(5);

    // ---------------- Flush mid-operation ----------------
    out_ready = 1'b0;
    m = bit_of(0) | bit_of(1) | bit_of(2);
    req_set = m;
    tick();
    req_set = '0;
    tick();
    check_val("fl_held_idx", 32'(out_index), 32'd2);
    flush   = 1'b1;
    req_set = bit_of(9);
    tick();
    flush   = 1'b0;
    req_set = '0;
    check_val("fl_valid", 32'(out_valid),   32'd0);
    check_val("fl_pany",  32'(pending_any), 32'd0);
    check_val("fl_dup",   32'(dup_cnt),     32'd1);
    out_ready = 1'b1;
    repeat (5) tick();
    check_val("fl_no_grant", 32'(out_valid), 32'd0);

    // ---------------- Random burst: strict descending, no bubbles ----------
    m = '0;
    for (int k = 0; k < 8; k++) m[$urandom_range(N - 1, 0)] = 1'b1;
    req_set = m;
    push_desc(m);
    tick();
    req_set = '0;
    wait_drain(20);
    tick();
    check_val("rnd_end_valid", 32'(out_valid), 32'd0);

    // ---------------- dup_cnt saturation ----------------
    out_ready = 1'b0;
    req_set = bit_of(6) | bit_of(5);
    tick();
    req_set = bit_of(5);
    repeat (65540) tick();
    check_val("sat_cnt", 32'(dup_cnt), 32'hFFFF);
    tick();
    req_set = '0;
    check_val("sat_hold", 32'(dup_cnt), 32'hFFFF);
    check_val("sat_idx",  32'(out_index), 32'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("sat_flush_dup", 32'(dup_cnt), 32'hFFFF);

    // ---------------- Asynchronous reset mid-transfer ----------------
    req_set = bit_of(7);
    tick();
    req_set = '0;
    tick();
    check_val("ar_pre_valid", 32'(out_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_val("ar_valid", 32'(out_valid),   32'd0);
    check_val("ar_index", 32'(out_index),   32'd0);
    check_val("ar_pany",  32'(pending_any), 32'd0);
    check_val("ar_dup",   32'(dup_cnt),     32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_val("ar_after_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
